pfpu_dispatch: RTL and testbench

Instruction issue and writeback scheduler for the PFPU datapath. It accepts decoded instructions from the sequencer and drives the register-file read addresses and the ALU opcode. It tracks each instruction's fixed ALU latency in a result schedule and turns ALU results into register-file writes to the correct destination. It stalls issue when two results would return in the same cycle, and flags any ALU result that arrives when none is expected (or fails to arrive when one is).

---
 rtl/pfpu_dispatch_pkg.sv | 42 ++++
 rtl/pfpu_sched.sv | 40 ++++
 rtl/pfpu_dispatch.sv | 84 ++++++++
 tb/tb_pfpu_dispatch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfpu_dispatch_pkg.sv
// Opcode map, per-opcode ALU latency and schedule entry type for the PFPU dispatcher.
// Shared by the sequencer, compiler tables and dispatch datapath.
package pfpu_dispatch_pkg;

    typedef enum logic [3:0] {
        OP_NOP     = 4'h0,
        OP_FADD    = 4'h1,
        OP_FSUB    = 4'h2,
        OP_FMUL    = 4'h3,
        OP_ABS     = 4'h4,
        OP_F2I     = 4'h5,
        OP_I2F     = 4'h6,
        OP_VECTOUT = 4'h7,
        OP_SIN     = 4'h8,
        OP_COS     = 4'h9,
        OP_ABOVE   = 4'hA,
        OP_EQUAL   = 4'hB,
        OP_COPY    = 4'hC,
        OP_IF      = 4'hD,
        OP_TSIGN   = 4'hE,
        OP_QUAKE   = 4'hF
    } opcode_t;

    localparam int MAX_LAT = 5;

    typedef struct packed {
        logic       vld;
        logic [6:0] dest;
    } sched_ent_t;

    // Cycles from alu_opcode being driven to r_valid; 0 means no result.
    function automatic logic [2:0] op_latency(input logic [3:0] op);
        case (opcode_t'(op))
            OP_NOP, OP_VECTOUT:     return 3'd0;
            OP_FADD, OP_FSUB:       return 3'd5;
            OP_FMUL, OP_SIN, OP_COS: return 3'd4;
            OP_I2F:                 return 3'd3;
            default:                return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/pfpu_sched.sv
// Result schedule: shift register of {valid, dest}, entry k returns k cycles from now.
// Insert lands one cycle later; no backpressure, caller guarantees the target slot is free.
module pfpu_sched
    import pfpu_dispatch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             ins_en,
    input  logic [IDX_W-1:0] ins_idx,
    input  logic [6:0]       ins_dest,
    output logic [DEPTH-1:0] occupied,
    output logic             head_vld,
    output logic [6:0]       head_dest
);

    sched_ent_t sched [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) sched[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH - 1; k++) sched[k] <= sched[k + 1];
            sched[DEPTH-1] <= '0;
            // Insert overrides the shifted value; the issue precheck keeps that slot empty.
            if (ins_en) sched[ins_idx] <= '{vld: 1'b1, dest: ins_dest};
        end
    end

    always_comb begin
        occupied = '0;
        for (int k = 0; k < DEPTH; k++) occupied[k] = sched[k].vld;
    end

    assign head_vld  = sched[0].vld;
    assign head_dest = sched[0].dest;

endmodule

// File: rtl/pfpu_dispatch.sv
// PFPU issue/writeback scheduler: registers opcode and read addresses one cycle after accept.
// Stalls issue (instr_ready low) when the new result slot would collide with one already scheduled.
module pfpu_dispatch
    import pfpu_dispatch_pkg::*;
#(
    parameter int SCHED_DEPTH = 8
) (
    input  logic        sys_clk,
    input  logic        alu_rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  instr_opcode,
    input  logic [6:0]  instr_a,
    input  logic [6:0]  instr_b,
    input  logic [6:0]  instr_dest,
    output logic [6:0]  a_addr,
    output logic [6:0]  b_addr,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] r,
    input  logic        r_valid,
    input  logic        alu_collision,
    output logic        w_en,
    output logic [6:0]  w_addr,
    output logic [31:0] w_data,
    output logic        idle,
    output logic        err_mismatch,
    output logic        err_collision
);

    localparam int IDX_W = $clog2(SCHED_DEPTH);

    logic [2:0]             lat;
    logic [IDX_W-1:0]       lat_idx;
    logic [IDX_W-1:0]       chk_idx;
    logic [SCHED_DEPTH-1:0] occupied;
    logic                   head_vld;
    logic [6:0]             head_dest;
    logic                   accept;
    logic                   has_result;

    assign lat        = op_latency(instr_opcode);
    assign lat_idx    = IDX_W'(lat);
    assign chk_idx    = lat_idx + IDX_W'(1);
    assign has_result = (lat != 3'd0);

    assign instr_ready = !alu_rst && (!has_result || !occupied[chk_idx]);
    assign accept      = instr_valid && instr_ready;

    pfpu_sched #(
        .DEPTH (SCHED_DEPTH)
    ) u_sched (
        .sys_clk   (sys_clk),
        .rst       (alu_rst),
        .ins_en    (accept && has_result),
        .ins_idx   (lat_idx),
        .ins_dest  (instr_dest),
        .occupied  (occupied),
        .head_vld  (head_vld),
        .head_dest (head_dest)
    );

    // Gated by reset so a stale head entry cannot write during the reset cycle.
    assign w_en   = !alu_rst && head_vld && r_valid;
    assign w_addr = head_dest;
    assign w_data = r;
    assign idle   = alu_rst || (!(|occupied) && !(accept && has_result));

    always_ff @(posedge sys_clk) begin
        if (alu_rst) begin
            alu_opcode    <= OP_NOP;
            a_addr        <= '0;
            b_addr        <= '0;
            err_mismatch  <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            alu_opcode <= accept ? instr_opcode : OP_NOP;
            a_addr     <= accept ? instr_a : 7'd0;
            b_addr     <= accept ? instr_b : 7'd0;
            if (r_valid != head_vld) err_mismatch <= 1'b1;
            if (alu_collision)       err_collision <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pfpu_dispatch.sv
// Directed bench for pfpu_dispatch: inputs driven 1 time unit after the rising edge,
// outputs sampled 2 units later, well clear of the next edge.
module tb_pfpu_dispatch;

    logic        sys_clk;
    logic        alu_rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_opcode;
    logic [6:0]  instr_a;
    logic [6:0]  instr_b;
    logic [6:0]  instr_dest;
    logic [6:0]  a_addr;
    logic [6:0]  b_addr;
    logic [3:0]  alu_opcode;
    logic [31:0] r;
    logic        r_valid;
    logic        alu_collision;
    logic        w_en;
    logic [6:0]  w_addr;
    logic [31:0] w_data;
    logic        idle;
    logic        err_mismatch;
    logic        err_collision;

    int errors = 0;
    int checks = 0;

    pfpu_dispatch #(.SCHED_DEPTH(8)) dut (
        .sys_clk       (sys_clk),
        .alu_rst       (alu_rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_a       (instr_a),
        .instr_b       (instr_b),
        .instr_dest    (instr_dest),
        .a_addr        (a_addr),
        .b_addr        (b_addr),
        .alu_opcode    (alu_opcode),
        .r             (r),
        .r_valid       (r_valid),
        .alu_collision (alu_collision),
        .w_en          (w_en),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .idle          (idle),
        .err_mismatch  (err_mismatch),
        .err_collision (err_collision)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance to the next cycle; inputs may be changed immediately afterwards.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic offer(input logic [3:0] op, input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] d);
        instr_valid  = 1'b1;
        instr_opcode = op;
        instr_a      = a;
        instr_b      = b;
        instr_dest   = d;
    endtask

    task automatic test_reset();
        alu_rst = 1'b1;
        offer(4'h1, 7'd9, 7'd9, 7'd9);
        tick();
        tick();
        settle();
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", instr_ready); end
        checks++; if (alu_opcode !== 4'h0) begin errors++; $display("FAIL rst_opcode: got %h want 0", alu_opcode); end
        checks++; if (a_addr !== 7'd0 || b_addr !== 7'd0) begin errors++; $display("FAIL rst_addr: got %0d/%0d want 0/0", a_addr, b_addr); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", idle); end
        checks++; if (w_en !== 1'b0 || err_mismatch !== 1'b0 || err_collision !== 1'b0) begin errors++; $display("FAIL rst_flags: got w_en=%b mis=%b col=%b want 0/0/0", w_en, err_mismatch, err_collision); end
        instr_valid = 1'b0;
        alu_rst     = 1'b0;
        tick();
    endtask

    task automatic test_single_fadd();
        offer(4'h1, 7'd3, 7'd4, 7'd12);
        settle();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL fadd_ready: got %b want 1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            settle();
            if (c == 1) begin
                checks++; if (alu_opcode !== 4'h1 || a_addr !== 7'd3 || b_addr !== 7'd4) begin errors++; $display("FAIL fadd_issue: got op=%h a=%0d b=%0d want 1/3/4", alu_opcode, a_addr, b_addr); end
                checks++; if (idle !== 1'b0) begin errors++; $display("FAIL fadd_busy: got idle=%b want 0", idle); end
            end
            checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL fadd_early_wen c=%0d: got %b want 0", c, w_en); end
            tick();
        end
        r_valid = 1'b1;
        r       = 32'h4040_0000;
        settle();
        checks++; if (w_en !== 1'b1 || w_addr !== 7'd12 || w_data !== 32'h4040_0000) begin errors++; $display("FAIL fadd_write: got en=%b addr=%0d data=%h want 1/12/40400000", w_en, w_addr, w_data); end
        tick();
        r_valid = 1'b0;
        settle();
        checks++; if (idle !== 1'b1 || err_mismatch !== 1'b0 || alu_opcode !== 4'h0) begin errors++; $display("FAIL fadd_after: got idle=%b mis=%b op=%h want 1/0/0", idle, err_mismatch, alu_opcode); end
    endtask

    task automatic test_slot_stall();
        offer(4'h1, 7'd1, 7'd2, 7'd20);
        tick();
        offer(4'h3, 7'd5, 7'd6, 7'd21);
        settle();
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_t1: got %b want 0", instr_ready); end
        tick();
        settle();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_t2: got %b want 1", instr_ready); end
        checks++; if (alu_opcode !== 4'h0 || a_addr !== 7'd0) begin errors++; $display("FAIL stall_nop_issue: got op=%h a=%0d want 0/0", alu_opcode, a_addr); end
        tick();
        instr_valid = 1'b0;
        settle();
        checks++; if (alu_opcode !== 4'h3 || a_addr !== 7'd5 || b_addr !== 7'd6) begin errors++; $display("FAIL stall_fmul_issue: got op=%h a=%0d b=%0d want 3/5/6", alu_opcode, a_addr, b_addr); end
        tick();
        tick();
        tick();
        r_valid = 1'b1;
        r       = 32'hAAAA_0001;
        settle();
        checks++; if (w_en !== 1'b1 || w_addr !== 7'd20 || w_data !== 32'hAAAA_0001) begin errors++; $display("FAIL stall_write_fadd: got en=%b addr=%0d data=%h want 1/20/aaaa0001", w_en, w_addr, w_data); end
        tick();
        r = 32'hBBBB_0002;
        settle();
        checks++; if (w_en !== 1'b1 || w_addr !== 7'd21 || w_data !== 32'hBBBB_0002) begin errors++; $display("FAIL stall_write_fmul: got en=%b addr=%0d data=%h want 1/21/bbbb0002", w_en, w_addr, w_data); end
        tick();
        r_valid = 1'b0;
        settle();
        checks++; if (err_mismatch !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL stall_clean: got mis=%b idle=%b want 0/1", err_mismatch, idle); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] dests [3];
        dests[0] = 7'd30;
        dests[1] = 7'd31;
        dests[2] = 7'd32;
        for (int i = 0; i < 3; i++) begin
            offer(4'hC, 7'(i), 7'(i + 8), dests[i]);
            settle();
            checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL dense_ready i=%0d: got %b want 1", i, instr_ready); end
            tick();
        end
        instr_valid = 1'b0;
        r_valid     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r = 32'd100 + 32'(i);
            settle();
            checks++; if (w_en !== 1'b1 || w_addr !== dests[i] || w_data !== 32'd100 + 32'(i)) begin errors++; $display("FAIL dense_write i=%0d: got en=%b addr=%0d data=%0d want 1/%0d/%0d", i, w_en, w_addr, w_data, dests[i], 100 + i); end
            tick();
        end
        r_valid = 1'b0;
        settle();
        checks++; if (idle !== 1'b1 || w_en !== 1'b0 || err_mismatch !== 1'b0) begin errors++; $display("FAIL dense_end: got idle=%b en=%b mis=%b want 1/0/0", idle, w_en, err_mismatch); end
    endtask

    task automatic test_nop_vectout();
        logic [3:0] ops [2];
        ops[0] = 4'h0;
        ops[1] = 4'h7;
        for (int i = 0; i < 2; i++) begin
            offer(ops[i], 7'd1, 7'd2, 7'd50);
            settle();
            checks++; if (instr_ready !== 1'b1 || idle !== 1'b1) begin errors++; $display("FAIL nop_accept op=%h: got ready=%b idle=%b want 1/1", ops[i], instr_ready, idle); end
            tick();
        end
        instr_valid = 1'b0;
        settle();
        checks++; if (alu_opcode !== 4'h7) begin errors++; $display("FAIL vectout_issue: got %h want 7", alu_opcode); end
        for (int c = 0; c < 6; c++) begin
            settle();
            checks++; if (w_en !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL nop_quiet c=%0d: got en=%b idle=%b want 0/1", c, w_en, idle); end
            tick();
        end
        checks++; if (err_mismatch !== 1'b0) begin errors++; $display("FAIL nop_mismatch: got %b want 0", err_mismatch); end
    endtask

    task automatic test_reset_midflight();
        offer(4'h1, 7'd1, 7'd1, 7'd40);
        tick();
        offer(4'h2, 7'd2, 7'd2, 7'd41);
        settle();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL mid_second_ready: got %b want 1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        alu_rst     = 1'b1;
        settle();
        checks++; if (idle !== 1'b1 || instr_ready !== 1'b0) begin errors++; $display("FAIL mid_in_reset: got idle=%b ready=%b want 1/0", idle, instr_ready); end
        tick();
        alu_rst = 1'b0;
        settle();
        checks++; if (idle !== 1'b1 || alu_opcode !== 4'h0) begin errors++; $display("FAIL mid_after_reset: got idle=%b op=%h want 1/0", idle, alu_opcode); end
        for (int c = 0; c < 8; c++) begin
            settle();
            checks++; if (w_en !== 1'b0 || err_mismatch !== 1'b0) begin errors++; $display("FAIL mid_dropped c=%0d: got en=%b mis=%b want 0/0", c, w_en, err_mismatch); end
            tick();
        end
    endtask

    task automatic test_spurious_and_collision();
        r_valid = 1'b1;
        r       = 32'hDEAD_BEEF;
        settle();
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL spur_wen: got %b want 0", w_en); end
        checks++; if (err_mismatch !== 1'b0) begin errors++; $display("FAIL spur_before: got %b want 0", err_mismatch); end
        tick();
        r_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++; if (err_mismatch !== 1'b1) begin errors++; $display("FAIL spur_sticky c=%0d: got %b want 1", c, err_mismatch); end
            tick();
        end
        checks++; if (err_collision !== 1'b0) begin errors++; $display("FAIL col_before: got %b want 0", err_collision); end
        alu_collision = 1'b1;
        tick();
        alu_collision = 1'b0;
        tick();
        settle();
        checks++; if (err_collision !== 1'b1) begin errors++; $display("FAIL col_sticky: got %b want 1", err_collision); end
        alu_rst = 1'b1;
        tick();
        alu_rst = 1'b0;
        settle();
        checks++; if (err_mismatch !== 1'b0 || err_collision !== 1'b0) begin errors++; $display("FAIL err_clear: got mis=%b col=%b want 0/0", err_mismatch, err_collision); end
    endtask

    initial begin
        alu_rst       = 1'b1;
        instr_valid   = 1'b0;
        instr_opcode  = 4'h0;
        instr_a       = 7'd0;
        instr_b       = 7'd0;
        instr_dest    = 7'd0;
        r             = 32'd0;
        r_valid       = 1'b0;
        alu_collision = 1'b0;
        test_reset();
        test_single_fadd();
        tick();
        test_slot_stall();
        tick();
        test_back_to_back();
        tick();
        test_nop_vectout();
        test_reset_midflight();
        test_spurious_and_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
